// File: rtl/uart_rx_os7_pkg.sv
// -----------------------------------------------------------------------------
// uart_rx_os7_pkg
// Shared UART definitions: FSM state encoding, default oversampling rate,
// sample-point indices within a bit period and the 2-of-3 majority helper.
// Intended to be shared with the matching transmitter.
// -----------------------------------------------------------------------------
package uart_rx_os7_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } uart_state_e;

  // baud_tick pulses per bit period (divider is set to clk/baud/OS_RATE)
  localparam int OS_RATE_DEF = 7;

  // Sample-counter values at which the line is captured inside one bit
  localparam int SMP_A = 2;
  localparam int SMP_B = 3;
  localparam int SMP_C = 4;

  // Sample-counter value that closes a start/data bit, and the stop bit
  localparam int START_END = 6;
  localparam int STOP_END  = 4;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_os7_bit_sync.sv
// -----------------------------------------------------------------------------
// uart_rx_os7_bit_sync
// STAGES-deep flip-flop synchronizer for a single asynchronous input.
// Reset loads RST_VAL into every stage so an idle-high line never shows a
// false edge when reset is released.
// Ports:
//   clk  in  system clock
//   rst  in  synchronous reset, active-high
//   i_d  in  asynchronous input
//   o_q  out synchronized copy of i_d, STAGES clocks late
// -----------------------------------------------------------------------------
module uart_rx_os7_bit_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_chain;

  // NOTE: sequential state uses <= so every stage samples the pre-edge value
  // of its neighbour; blocking = would collapse the chain into one flop.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_chain <= {STAGES{RST_VAL}};
    end else begin
      r_chain[0] <= i_d;
      for (int i = 1; i < STAGES; i++) begin
        r_chain[i] <= r_chain[i-1];
      end
    end
  end

  assign o_q = r_chain[STAGES-1];

endmodule

// File: rtl/uart_rx_os7.sv
// -----------------------------------------------------------------------------
// uart_rx_os7
// 8N1 UART receiver, LSB first, driven by an oversampling tick from the baud
// divider (OS_RATE ticks per bit). Each bit is captured at three sample points
// and resolved by 2-of-3 majority. Good bytes are presented with a one-clock
// rx_valid strobe; a stop bit sampled low gives a one-clock rx_ferr strobe.
// Ports:
//   clk        in   system clock, single domain
//   rst        in   synchronous reset, active-high
//   baud_tick  in   one-clock pulse, OS_RATE per bit period
//   rxd        in   asynchronous serial line, idle high
//   rx_data    out  last good byte, held until the next good byte
//   rx_valid   out  one-clock strobe: rx_data updated this cycle
//   rx_ferr    out  one-clock strobe: frame ended with stop sample 0
//   rx_busy    out  high while a frame is being received
// -----------------------------------------------------------------------------
module uart_rx_os7
  import uart_rx_os7_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int OS_RATE     = OS_RATE_DEF,
  parameter int SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 rx_ferr,
  output logic                 rx_busy
);

  localparam int SC_W  = (OS_RATE   > 1) ? $clog2(OS_RATE)   : 1;
  localparam int BIT_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [SC_W-1:0]  SC_A      = SC_W'(SMP_A);
  localparam logic [SC_W-1:0]  SC_B      = SC_W'(SMP_B);
  localparam logic [SC_W-1:0]  SC_C      = SC_W'(SMP_C);
  localparam logic [SC_W-1:0]  SC_BITEND = SC_W'(START_END);
  localparam logic [SC_W-1:0]  SC_STOPEND = SC_W'(STOP_END);
  localparam logic [BIT_W-1:0] BIT_LAST  = BIT_W'(DATA_BITS - 1);

  // ---------------------------------------------------------------------------
  // Input synchronizer
  // ---------------------------------------------------------------------------
  logic w_rxs;

  uart_rx_os7_bit_sync #(
    .STAGES  (SYNC_STAGES),
    .RST_VAL (1'b1)
  ) u_rxd_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxs)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  uart_state_e          r_state,  w_state_nxt;
  logic [SC_W-1:0]      r_sc,     w_sc_nxt;
  logic [BIT_W-1:0]     r_bit,    w_bit_nxt;
  logic [DATA_BITS-1:0] r_shreg,  w_shreg_nxt;
  logic [2:0]           r_smp,    w_smp_nxt;    // captures at SC_A/SC_B/SC_C
  logic                 r_armed,  w_armed_nxt;
  logic [DATA_BITS-1:0] r_data,   w_data_nxt;
  logic                 r_valid,  w_valid_nxt;
  logic                 r_ferr,   w_ferr_nxt;

  logic w_vote;       // majority of the three stored captures
  logic w_vote_stop;  // stop bit closes on its third sample, so use it live

  assign w_vote      = maj3(r_smp[0], r_smp[1], r_smp[2]);
  assign w_vote_stop = maj3(r_smp[0], r_smp[1], w_rxs);

  // ---------------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------------
  // NOTE: every variable gets a default before any branch; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_sc_nxt    = r_sc;
    w_bit_nxt   = r_bit;
    w_shreg_nxt = r_shreg;
    w_smp_nxt   = r_smp;
    w_armed_nxt = r_armed;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;     // strobes fall on the next clock, tick or not
    w_ferr_nxt  = 1'b0;

    if (baud_tick) begin
      // A high line re-arms start detection; a held-low break never does.
      if (w_rxs) begin
        w_armed_nxt = 1'b1;
      end

      if (r_state != ST_IDLE) begin
        if (r_sc == SC_A) w_smp_nxt[0] = w_rxs;
        if (r_sc == SC_B) w_smp_nxt[1] = w_rxs;
        if (r_sc == SC_C) w_smp_nxt[2] = w_rxs;
        w_sc_nxt = r_sc + SC_W'(1);
      end

      unique case (r_state)
        ST_IDLE: begin
          if (r_armed && !w_rxs) begin
            w_state_nxt = ST_START;
            w_sc_nxt    = SC_W'(1);   // detect tick is sample 0
          end
        end

        ST_START: begin
          if (r_sc == SC_BITEND) begin
            w_sc_nxt  = '0;
            w_bit_nxt = '0;
            // A start bit that votes high was a glitch: drop it silently.
            w_state_nxt = w_vote ? ST_IDLE : ST_DATA;
          end
        end

        ST_DATA: begin
          if (r_sc == SC_BITEND) begin
            w_sc_nxt    = '0;
            w_shreg_nxt = {w_vote, r_shreg[DATA_BITS-1:1]};
            if (r_bit == BIT_LAST) begin
              w_state_nxt = ST_STOP;
            end else begin
              w_bit_nxt = r_bit + BIT_W'(1);
            end
          end
        end

        ST_STOP: begin
          // Leave two ticks early so a back-to-back start edge is not missed.
          if (r_sc == SC_STOPEND) begin
            if (w_vote_stop) begin
              w_data_nxt  = r_shreg;
              w_valid_nxt = 1'b1;
            end else begin
              w_ferr_nxt  = 1'b1;
            end
            w_state_nxt = ST_IDLE;
            w_sc_nxt    = '0;
            w_armed_nxt = 1'b0;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_sc_nxt    = '0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_sc    <= '0;
      r_bit   <= '0;
      r_shreg <= '0;
      r_smp   <= '0;
      r_armed <= 1'b0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_sc    <= w_sc_nxt;
      r_bit   <= w_bit_nxt;
      r_shreg <= w_shreg_nxt;
      r_smp   <= w_smp_nxt;
      r_armed <= w_armed_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  assign rx_data  = r_data;
  assign rx_valid = r_valid;
  assign rx_ferr  = r_ferr;
  assign rx_busy  = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_os7.sv
// -----------------------------------------------------------------------------
// tb_uart_rx_os7
// Directed bench for uart_rx_os7. A divider model pulses baud_tick once every
// 64 clocks; the line is driven one tick at a time, with each frame laid out
// as 70 ticks (start, 8 data bits, stop, 7 ticks each).
// -----------------------------------------------------------------------------
module tb_uart_rx_os7;

  logic       clk = 1'b0;
  logic       rst;
  logic       baud_tick;
  logic       rxd;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ferr;
  logic       rx_busy;

  int total   = 0;
  int bad     = 0;
  int n_valid = 0;
  int n_ferr  = 0;

  always #5 clk = ~clk;

  uart_rx_os7 #(
    .DATA_BITS   (8),
    .OS_RATE     (7),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .baud_tick (baud_tick),
    .rxd       (rxd),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_ferr   (rx_ferr),
    .rx_busy   (rx_busy)
  );

  // Divider model: one-clock tick every 64 clocks, driven on the falling edge.
  initial begin
    baud_tick = 1'b0;
    forever begin
      repeat (63) @(negedge clk);
      baud_tick = 1'b1;
      @(negedge clk);
      baud_tick = 1'b0;
    end
  end

  initial begin
    #(100000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Strobe monitor: counts pulses and checks they never coincide.
  always @(negedge clk) begin
    if (rx_valid === 1'b1 || rx_ferr === 1'b1) begin
      if (rx_valid === 1'b1) n_valid++;
      if (rx_ferr === 1'b1)  n_ferr++;
      check("strobe_exclusive", {31'd0, rx_valid & rx_ferr}, 32'd0);
    end
  end

  // Drive the line for one tick, return 1 ns after the tick's clock edge.
  task automatic do_tick(input logic v);
    int n;
    @(negedge clk);
    rxd = v;
    n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (baud_tick !== 1'b1 && n < 80);
    if (baud_tick !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL tick_timeout: observed=no_tick expected=tick_within_80_clk");
    end
    #1;
  endtask

  // Line level at tick k of a frame (7 ticks per bit; bit 0 start, 9 stop).
  function automatic logic lvl(input logic [7:0] d, input logic stop,
                               input logic inv3, input int k);
    int   b;
    int   s;
    logic v;
    b = k / 7;
    s = k % 7;
    if (b == 0)      v = 1'b0;
    else if (b <= 8) v = d[b-1];
    else             v = stop;
    if (inv3 && s == 3) v = ~v;
    return v;
  endfunction

  // Send one full frame (70 ticks) and check the strobe on stop tick 4 (k=67).
  task automatic send_frame(input logic [7:0] d, input logic stop, input logic inv3,
                            input logic exp_v, input logic [7:0] exp_d, input string tag);
    int v0;
    int f0;
    v0 = n_valid;
    f0 = n_ferr;
    for (int k = 0; k < 70; k++) begin
      do_tick(lvl(d, stop, inv3, k));
      if (k == 0)  check({tag, "_busy_at_start"}, {31'd0, rx_busy}, 32'd1);
      if (k == 66) check({tag, "_no_early_strobe"}, {30'd0, rx_valid, rx_ferr}, 32'd0);
      if (k == 67) begin
        check({tag, "_valid"}, {31'd0, rx_valid}, {31'd0, exp_v});
        check({tag, "_ferr"},  {31'd0, rx_ferr},  {31'd0, ~exp_v});
        check({tag, "_data"},  {24'd0, rx_data},  {24'd0, exp_d});
        @(posedge clk);
        #1;
        check({tag, "_strobe_width"}, {30'd0, rx_valid, rx_ferr}, 32'd0);
      end
      if (k == 68) check({tag, "_busy_after"}, {31'd0, rx_busy}, 32'd0);
    end
    check({tag, "_valid_count"}, n_valid - v0, {31'd0, exp_v});
    check({tag, "_ferr_count"},  n_ferr - f0,  {31'd0, ~exp_v});
  endtask

  initial begin
    rst = 1'b1;
    rxd = 1'b1;
    repeat (3) @(negedge clk);

    // Reset state
    check("rst_data",  {24'd0, rx_data}, 32'd0);
    check("rst_valid", {31'd0, rx_valid}, 32'd0);
    check("rst_ferr",  {31'd0, rx_ferr}, 32'd0);
    check("rst_busy",  {31'd0, rx_busy}, 32'd0);
    rst = 1'b0;

    // Idle high to arm start detection
    do_tick(1'b1);
    do_tick(1'b1);

    // 1: clean 0xA5
    send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8'hA5, "t1_a5");

    // 2: back-to-back frames, no idle beyond the stop bit
    send_frame(8'h00, 1'b1, 1'b0, 1'b1, 8'h00, "t2_00");
    send_frame(8'hFF, 1'b1, 1'b0, 1'b1, 8'hFF, "t2_ff");
    send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 8'h3C, "t2_3c");
    check("t2_total_valid", n_valid, 32'd4);

    // 3: one-tick low glitch: START for 7 ticks, then back to IDLE silently
    do_tick(1'b0);
    check("t3_busy_detect", {31'd0, rx_busy}, 32'd1);
    for (int i = 0; i < 5; i++) do_tick(1'b1);
    check("t3_busy_mid", {31'd0, rx_busy}, 32'd1);
    do_tick(1'b1);
    check("t3_busy_end", {31'd0, rx_busy}, 32'd0);
    check("t3_data_kept", {24'd0, rx_data}, 32'h3C);
    check("t3_no_strobe", n_valid + n_ferr, 32'd4);

    // 4: stop bit low -> framing error; break held low must not restart
    send_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'h3C, "t4_55");
    for (int i = 0; i < 21; i++) begin
      do_tick(1'b0);
      if (i == 0 || i == 20) check("t4_break_idle", {31'd0, rx_busy}, 32'd0);
    end
    check("t4_break_no_strobe", n_valid + n_ferr, 32'd5);
    do_tick(1'b1);
    check("t4_rearm_idle", {31'd0, rx_busy}, 32'd0);

    // 5: 0x81 with sample 3 of every bit inverted -> majority recovers it
    send_frame(8'h81, 1'b1, 1'b1, 1'b1, 8'h81, "t5_81");

    // 6: reset during data bit 4 of 0xC3, then a clean 0x12
    for (int k = 0; k < 37; k++) do_tick(lvl(8'hC3, 1'b1, 1'b0, k));
    check("t6_busy_mid_frame", {31'd0, rx_busy}, 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("t6_rst_busy", {31'd0, rx_busy}, 32'd0);
    check("t6_rst_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    do_tick(1'b1);
    check("t6_idle_after_rst", {31'd0, rx_busy}, 32'd0);
    send_frame(8'h12, 1'b1, 1'b0, 1'b1, 8'h12, "t6_12");
    check("final_valid_count", n_valid, 32'd6);
    check("final_ferr_count",  n_ferr,  32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
